ihp_sram_1024x32_responder: RTL and testbench

Synthesizable responder for the fabric-side SRAM pin bundle. It answers the `A_*_SRAM` signals that the fabric's SRAM primitive drives, holding a 1024x32 bit-maskable array with registered read data. It also owns the pre-configuration initialization path: a valid/ready load port fills the array sequentially while `CONFIGURED_top` is low. It stands in for the IHP macro in tile-level simulation and emulation builds, and acts as the SRAM init engine for the top level.

---
 rtl/ihp_sram_1024x32_responder.sv | 202 ++++++++++++++++++++
 tb/tb_ihp_sram_1024x32_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ihp_sram_1024x32_responder.sv
// ihp_sram_1024x32_responder
//
// Behavioural stand-in for the IHP 1024x32 SRAM macro on the fabric-side pin bundle.
// The module also acts as the pre-configuration init engine. While CONFIGURED_top is low,
// a valid/ready load port fills the array sequentially from address 0. Once the fabric is
// configured, the A_*_SRAM port has bit-masked writes and registered, read-before-write
// read data.
//
// Optional feature: define IHP_SRAM_RESP_ZERO_FILL_EN to compile in a zero-fill pass after
// every reset. The pass writes 0 to all words and drives BUSY high while it runs. Without
// the macro, the FSM resets straight into LOAD and BUSY is tied low.
//
// Ports:
//   UserCLK         clock, shared with the fabric user clock
//   RESET           asynchronous, active-high reset
//   A_ADDR_SRAM     word address (fabric port)
//   A_DIN_SRAM      write data (fabric port)
//   A_BM_SRAM       per-bit write mask, 1 = write that bit
//   A_WEN_SRAM      write enable
//   A_MEN_SRAM      macro enable, required for any access
//   A_REN_SRAM      read enable
//   A_DOUT_SRAM     registered read data
//   CONFIGURED_top  fabric configured: selects the fabric port over the load port
//   LOAD_DATA       init word
//   LOAD_VALID      init word valid
//   LOAD_READY      an init word is accepted this cycle
//   LOAD_DONE       all words have been loaded
//   BUSY            zero-fill in progress

`timescale 1ns/1ps

module ihp_sram_1024x32_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  UserCLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] A_ADDR_SRAM,
    input  logic [DATA_WIDTH-1:0] A_DIN_SRAM,
    input  logic [DATA_WIDTH-1:0] A_BM_SRAM,
    input  logic                  A_WEN_SRAM,
    input  logic                  A_MEN_SRAM,
    input  logic                  A_REN_SRAM,
    output logic [DATA_WIDTH-1:0] A_DOUT_SRAM,
    input  logic                  CONFIGURED_top,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic                  LOAD_VALID,
    output logic                  LOAD_READY,
    output logic                  LOAD_DONE,
    output logic                  BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
        StZero = 2'd3,
`endif
        StLoad = 2'd0,
        StFull = 2'd1,
        StRun  = 2'd2
    } state_t;

`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
    localparam state_t RESET_STATE = StZero;
`else
    localparam state_t RESET_STATE = StLoad;
`endif

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   load_ptr_q;
    logic                    done_q;
    logic                    ready_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   dout_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Shared write port, fed by zero-fill, the load port or the fabric port.
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_wmask;

    logic                    load_fire;
    logic                    fabric_live;

    // ready_q is only ever high in LOAD, so this is the real handshake.
    assign load_fire   = (state_q == StLoad) && ready_q && LOAD_VALID;
    // The edge that sees CONFIGURED_top fall leaves RUN and must not touch the array.
    assign fabric_live = (state_q == StRun) && CONFIGURED_top && A_MEN_SRAM;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = load_ptr_q;
        mem_wdata = '0;
        mem_wmask = '1;
        unique case (state_q)
`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
            StZero: begin
                mem_we = 1'b1;
            end
`endif
            StLoad: begin
                mem_we    = load_fire;
                mem_wdata = LOAD_DATA;
            end
            StRun: begin
                mem_we    = fabric_live && A_WEN_SRAM;
                mem_addr  = A_ADDR_SRAM;
                mem_wdata = A_DIN_SRAM;
                mem_wmask = A_BM_SRAM;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Array is deliberately not reset; only zero-fill (when built in) initialises it.
    always_ff @(posedge UserCLK) begin
        if (mem_we) begin
            mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    // Control FSM with registered outputs. LOAD_READY rises one edge after LOAD is entered.
    // It drops on the same edge that leaves LOAD, so no handshake is ever offered outside
    // LOAD.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RESET_STATE;
            load_ptr_q <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
            busy_q     <= 1'b1;
`else
            busy_q     <= 1'b0;
`endif
            dout_q     <= '0;
        end else begin
            case (state_q)
`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
                StZero: begin
                    ready_q    <= 1'b0;
                    load_ptr_q <= load_ptr_q + ADDR_WIDTH'(1);
                    if (load_ptr_q == LAST_ADDR) begin
                        load_ptr_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= StLoad;
                    end
                end
`endif
                StLoad: begin
                    ready_q <= 1'b1;
                    if (load_fire) begin
                        load_ptr_q <= load_ptr_q + ADDR_WIDTH'(1);
                        if (load_ptr_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            state_q <= StFull;
                        end
                    end
                    // Configuration wins over FULL; a same-edge handshake is still written.
                    if (CONFIGURED_top) begin
                        ready_q <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StFull: begin
                    ready_q <= 1'b0;
                    if (CONFIGURED_top) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    ready_q <= 1'b0;
                    if (!CONFIGURED_top) begin
                        // Reconfiguration: reload from address 0; contents and read data kept.
                        load_ptr_q <= '0;
                        done_q     <= 1'b0;
                        state_q    <= StLoad;
                    end else if (A_MEN_SRAM && A_REN_SRAM) begin
                        dout_q <= mem[A_ADDR_SRAM];
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= RESET_STATE;
                end
            endcase
        end
    end

    assign A_DOUT_SRAM = dout_q;
    assign LOAD_READY  = ready_q;
    assign LOAD_DONE   = done_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_ihp_sram_1024x32_responder.sv
`timescale 1ns/1ps

module tb_ihp_sram_1024x32_responder;

    localparam int DEPTH = 1024;

    logic        UserCLK = 1'b0;
    logic        RESET;
    logic [9:0]  A_ADDR_SRAM;
    logic [31:0] A_DIN_SRAM;
    logic [31:0] A_BM_SRAM;
    logic        A_WEN_SRAM;
    logic        A_MEN_SRAM;
    logic        A_REN_SRAM;
    logic [31:0] A_DOUT_SRAM;
    logic        CONFIGURED_top;
    logic [31:0] LOAD_DATA;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic        LOAD_DONE;
    logic        BUSY;

    ihp_sram_1024x32_responder #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32)
    ) dut (
        .UserCLK        (UserCLK),
        .RESET          (RESET),
        .A_ADDR_SRAM    (A_ADDR_SRAM),
        .A_DIN_SRAM     (A_DIN_SRAM),
        .A_BM_SRAM      (A_BM_SRAM),
        .A_WEN_SRAM     (A_WEN_SRAM),
        .A_MEN_SRAM     (A_MEN_SRAM),
        .A_REN_SRAM     (A_REN_SRAM),
        .A_DOUT_SRAM    (A_DOUT_SRAM),
        .CONFIGURED_top (CONFIGURED_top),
        .LOAD_DATA      (LOAD_DATA),
        .LOAD_VALID     (LOAD_VALID),
        .LOAD_READY     (LOAD_READY),
        .LOAD_DONE      (LOAD_DONE),
        .BUSY           (BUSY)
    );

    always #5 UserCLK = ~UserCLK;

`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model: array contents and expected read register.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_dout;

    typedef struct {
        logic        men;
        logic        ren;
        logic        wen;
        logic [9:0]  addr;
        logic [31:0] din;
        logic [31:0] bm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // One fabric-port cycle in RUN; the model reads before it writes.
    task automatic run_op(input logic men, input logic ren, input logic wen, input logic [9:0] addr,
                          input logic [31:0] din, input logic [31:0] bm);
        A_MEN_SRAM  = men;
        A_REN_SRAM  = ren;
        A_WEN_SRAM  = wen;
        A_ADDR_SRAM = addr;
        A_DIN_SRAM  = din;
        A_BM_SRAM   = bm;
        if (men) begin
            if (ren) model_dout = model_mem[addr];
            if (wen) model_mem[addr] = (model_mem[addr] & ~bm) | (din & bm);
        end
        tick();
        A_MEN_SRAM = 1'b0;
        A_REN_SRAM = 1'b0;
        A_WEN_SRAM = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [9:0] addr, input logic [31:0] exp);
        run_op(1'b1, 1'b1, 1'b0, addr, 32'h0, 32'h0);
        check(name, A_DOUT_SRAM, exp);
    endtask

    // Push one word while READY is expected high; ptr is the bench's own load pointer.
    task automatic load_word(input logic [31:0] data, inout int ptr);
        check("load_ready_pre", {31'b0, LOAD_READY}, 32'd1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = data;
        model_mem[ptr] = data;
        ptr++;
        tick();
        LOAD_VALID = 1'b0;
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!LOAD_READY && n < bound) begin
            tick();
            n++;
        end
        check("ready_wait", {31'b0, LOAD_READY}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int ptr;
        int cnt;
        logic fire;
        logic [31:0] hold;
        logic [9:0]  ra;
        logic [31:0] rbm;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 10'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hA5000000};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 10'd5, 32'h12345678, 32'h0000FF00, 32'hA5000000};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 10'd5, 32'h00000000, 32'h00000000, 32'hFFFF56FF};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 10'd7, 32'h11111111, 32'hFFFFFFFF, 32'hFFFF56FF};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 10'd7, 32'h22222222, 32'hFFFFFFFF, 32'h11111111};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 10'd7, 32'h00000000, 32'h00000000, 32'h22222222};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 10'd7, 32'h00000000, 32'hFFFFFFFF, 32'h22222222};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 10'd7, 32'h00000000, 32'h00000000, 32'h22222222};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 10'd9, 32'hFFFFFFFF, 32'h00000000, 32'hA5000009};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 10'd9, 32'h00000000, 32'h00000000, 32'hA5000009};

        RESET = 1'b1;
        A_ADDR_SRAM = '0; A_DIN_SRAM = '0; A_BM_SRAM = '0;
        A_WEN_SRAM = 1'b0; A_MEN_SRAM = 1'b0; A_REN_SRAM = 1'b0;
        CONFIGURED_top = 1'b0; LOAD_DATA = '0; LOAD_VALID = 1'b0;
        model_dout = 32'h0;

        tick();
        tick();
        check("rst_dout", A_DOUT_SRAM, 32'h0);
        check("rst_ready", {31'b0, LOAD_READY}, 32'd0);
        check("rst_done", {31'b0, LOAD_DONE}, 32'd0);
        check("rst_busy", {31'b0, BUSY}, {31'b0, ZF});
        RESET = 1'b0;

`ifdef IHP_SRAM_RESP_ZERO_FILL_EN
        model_zero();
        cnt = 0;
        while (BUSY && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("zf_busy_cycles", cnt, 32'd1024);
        check("zf_ready_lag", {31'b0, LOAD_READY}, 32'd0);
        tick();
        check("zf_ready_rise", {31'b0, LOAD_READY}, 32'd1);
        CONFIGURED_top = 1'b1;
        tick();
        read_chk("zf_rd0", 10'd0, 32'h0);
        read_chk("zf_rd511", 10'd511, 32'h0);
        read_chk("zf_rd1023", 10'd1023, 32'h0);
        CONFIGURED_top = 1'b0;
        tick();
        tick();
`else
        tick();
        check("busy_tied", {31'b0, BUSY}, 32'd0);
`endif
        check("load_ready_start", {31'b0, LOAD_READY}, 32'd1);

        // Full load with randomly toggling VALID.
        hs = 0;
        for (int cyc = 0; cyc < 8000 && hs < DEPTH; cyc++) begin
            LOAD_VALID = 1'($urandom_range(0, 1));
            LOAD_DATA  = 32'hA5000000 + 32'(hs);
            fire = LOAD_VALID && LOAD_READY;
            if (fire) model_mem[hs] = LOAD_DATA;
            tick();
            if (fire) hs++;
            check("load_done_track", {31'b0, LOAD_DONE}, {31'b0, hs == DEPTH});
            check("load_ready_track", {31'b0, LOAD_READY}, {31'b0, hs < DEPTH});
        end
        check("load_count", hs, 32'd1024);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 32'hDEADBEEF;
        tick();
        tick();
        LOAD_VALID = 1'b0;
        check("full_ready", {31'b0, LOAD_READY}, 32'd0);
        check("full_done", {31'b0, LOAD_DONE}, 32'd1);

        CONFIGURED_top = 1'b1;
        tick();
        check("run_done_kept", {31'b0, LOAD_DONE}, 32'd1);
        read_chk("rd1023", 10'd1023, 32'hA50003FF);
        read_chk("rd0_no_extra", 10'd0, 32'hA5000000);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].men, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].din, tbl[i].bm);
            check($sformatf("tbl%0d", i), A_DOUT_SRAM, tbl[i].exp);
        end

        for (int i = 0; i < 400; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       rbm = 32'hFFFFFFFF;
                1:       rbm = 32'h0;
                default: rbm = $urandom;
            endcase
            run_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ra, $urandom, rbm);
            check("rand", A_DOUT_SRAM, model_dout);
        end

        // Reconfiguration: the falling edge of CONFIGURED_top ignores a concurrent access.
        read_chk("pre_reconf_rd", 10'd3, model_mem[3]);
        hold = model_dout;
        A_MEN_SRAM = 1'b1; A_REN_SRAM = 1'b1; A_WEN_SRAM = 1'b1;
        A_ADDR_SRAM = 10'd500; A_DIN_SRAM = 32'h0BADF00D; A_BM_SRAM = 32'hFFFFFFFF;
        CONFIGURED_top = 1'b0;
        tick();
        A_MEN_SRAM = 1'b0; A_REN_SRAM = 1'b0; A_WEN_SRAM = 1'b0;
        check("reconf_dout_hold", A_DOUT_SRAM, hold);
        check("reconf_done_clr", {31'b0, LOAD_DONE}, 32'd0);
        check("reconf_ready_lag", {31'b0, LOAD_READY}, 32'd0);
        tick();
        check("reconf_ready", {31'b0, LOAD_READY}, 32'd1);

        // Reset in the middle of a load.
        ptr = 0;
        for (int i = 0; i < 100; i++) load_word(32'h5A000000 + 32'(i), ptr);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 32'hFEEDFACE;
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_dout", A_DOUT_SRAM, 32'h0);
        check("midrst_ready", {31'b0, LOAD_READY}, 32'd0);
        check("midrst_done", {31'b0, LOAD_DONE}, 32'd0);
        check("midrst_busy", {31'b0, BUSY}, {31'b0, ZF});
        LOAD_VALID = 1'b0;
        model_dout = 32'h0;
        tick();
        tick();
        RESET = 1'b0;
        if (ZF) model_zero();
        wait_ready(3000);

        // Configure on the same edge as the fourth handshake.
        ptr = 0;
        for (int i = 0; i < 3; i++) load_word(32'hC0DE0000 + 32'(i), ptr);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 32'hC0DE0003;
        model_mem[3] = LOAD_DATA;
        CONFIGURED_top = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        check("early_ready", {31'b0, LOAD_READY}, 32'd0);
        check("early_done", {31'b0, LOAD_DONE}, 32'd0);
        read_chk("early_rd3", 10'd3, 32'hC0DE0003);
        read_chk("early_rd4", 10'd4, model_mem[4]);
        read_chk("reload_rd0", 10'd0, 32'hC0DE0000);
        read_chk("reconf_no_wr", 10'd500, model_mem[500]);
        read_chk("kept_rd99", 10'd99, model_mem[99]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
